// File: rtl/fetch_if.sv
// Fetch-side bundle: execute redirect, decode stall, instruction memory and decode outputs.
// The master modport is the fetch sequencer; the slave modport is everything around it.
interface fetch_if;
    logic        PCSrc;
    logic [31:0] Result;
    logic        Stall;
    logic        IMemValid;
    logic [31:0] IMemRData;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PC_Plus_4;

    modport master (
        input  PCSrc, Result, Stall, IMemValid, IMemRData,
        output IMemReq, IMemAddr, Instr, InstrValid, PC, PC_Plus_4
    );

    modport slave (
        output PCSrc, Result, Stall, IMemValid, IMemRData,
        input  IMemReq, IMemAddr, Instr, InstrValid, PC, PC_Plus_4
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns fetch_pc, runs the req/valid memory handshake,
// holds one instruction plus a one-entry skid, and applies execute redirects.
//
// state | meaning
// IDLE  | post-reset, no request yet
// REQ   | request outstanding at fetch_pc
// HOLD  | Instr full and stalled, one word parked in the skid, no request
// KILL  | redirect arrived mid-access; finishing old access, target pending
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic     CLK,
    input  logic     Reset,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic [31:0] r_skid_data, w_skid_data_nxt;
    logic [31:0] r_skid_pc, w_skid_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_pc_p4, w_pc_p4_nxt;
    logic        r_valid, w_valid_nxt;

    logic        w_req;
    logic        w_done;
    logic        w_slot_free;
    logic [31:0] w_redir_pc;

    assign w_req       = (r_state == REQ) || (r_state == KILL);
    assign w_done      = w_req && bus.IMemValid;
    assign w_slot_free = !r_valid || !bus.Stall;
    assign w_redir_pc  = bus.Result & 32'hFFFF_FFFC;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_VECTOR;
            r_target    <= RESET_VECTOR;
            r_skid_data <= 32'h0;
            r_skid_pc   <= RESET_VECTOR;
            r_instr     <= 32'h0;
            r_pc        <= RESET_VECTOR;
            r_pc_p4     <= RESET_VECTOR + 32'd4;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_target    <= w_target_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_pc   <= w_skid_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_pc        <= w_pc_nxt;
            r_pc_p4     <= w_pc_p4_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_target_nxt    = r_target;
        w_skid_data_nxt = r_skid_data;
        w_skid_pc_nxt   = r_skid_pc;
        w_instr_nxt     = r_instr;
        w_pc_nxt        = r_pc;
        w_pc_p4_nxt     = r_pc_p4;
        w_valid_nxt     = r_valid && bus.Stall;

        unique case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                if (bus.PCSrc) w_fetch_pc_nxt = w_redir_pc;
            end
            REQ: begin
                if (bus.PCSrc) begin
                    w_valid_nxt = 1'b0;
                    if (w_done) begin
                        w_fetch_pc_nxt = w_redir_pc;
                    end else begin
                        // old address must stay on the bus until memory answers
                        w_target_nxt = w_redir_pc;
                        w_state_nxt  = KILL;
                    end
                end else if (w_done) begin
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    if (w_slot_free) begin
                        w_instr_nxt = bus.IMemRData;
                        w_pc_nxt    = r_fetch_pc;
                        w_pc_p4_nxt = r_fetch_pc + 32'd4;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_skid_data_nxt = bus.IMemRData;
                        w_skid_pc_nxt   = r_fetch_pc;
                        w_state_nxt     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.PCSrc) begin
                    w_valid_nxt    = 1'b0;
                    w_fetch_pc_nxt = w_redir_pc;
                    w_state_nxt    = REQ;
                end else if (w_slot_free) begin
                    w_instr_nxt = r_skid_data;
                    w_pc_nxt    = r_skid_pc;
                    w_pc_p4_nxt = r_skid_pc + 32'd4;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            KILL: begin
                w_valid_nxt = 1'b0;
                if (w_done) begin
                    w_fetch_pc_nxt = bus.PCSrc ? w_redir_pc : r_target;
                    w_state_nxt    = REQ;
                end else if (bus.PCSrc) begin
                    w_target_nxt = w_redir_pc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.IMemReq    = w_req;
    assign bus.IMemAddr   = r_fetch_pc;
    assign bus.Instr      = r_instr;
    assign bus.InstrValid = r_valid;
    assign bus.PC         = r_pc;
    assign bus.PC_Plus_4  = r_pc_p4;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios plus random stall/redirect/wait traffic.
module tb_fetch_sequencer;
    localparam logic [31:0] K  = 32'hA5A5_0000;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;
    fetch_if bus();

    fetch_sequencer #(.RESET_VECTOR(RV)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event not seen within bound", name);
    endtask

    // memory model: each access waits fixed_wait cycles (or random 0..3 when negative)
    int fixed_wait = 0;
    int left       = 0;
    bit active     = 0;
    bit req_cyc    = 0;
    bit val_cyc    = 0;
    initial begin
        bus.IMemValid = 1'b0;
        bus.IMemRData = 32'h0;
        forever begin
            @(posedge CLK); #1;
            if (!Reset) begin
                active = 0;
                bus.IMemValid = 1'b0;
            end else if (bus.IMemReq) begin
                if (!active || (req_cyc && val_cyc)) begin
                    active = 1;
                    left = (fixed_wait < 0) ? int'($urandom_range(3, 0)) : fixed_wait;
                end
                if (left == 0) begin
                    bus.IMemValid = 1'b1;
                    bus.IMemRData = bus.IMemAddr ^ K;
                end else begin
                    bus.IMemValid = 1'b0;
                    left--;
                end
            end else begin
                active = 0;
                bus.IMemValid = 1'b0;
            end
            req_cyc = bus.IMemReq && Reset;
            val_cyc = bus.IMemValid;
        end
    end

    // scoreboard: driver pushes redirect targets, monitor owns the expected instruction stream
    logic [31:0] redir_q[$];
    logic [31:0] exp_pc     = RV;
    int          n_consumed = 0;
    bit          p_hold     = 0;
    logic [31:0] p_addr     = 32'h0;

    always @(negedge CLK) begin
        if (!Reset) begin
            exp_pc = RV;
            redir_q.delete();
            p_hold = 0;
        end else begin
            if (p_hold) begin
                chk("req_held", {31'b0, bus.IMemReq}, 32'd1);
                chk("addr_stable", bus.IMemAddr, p_addr);
            end
            if (bus.InstrValid && !bus.Stall) begin
                chk("pc", bus.PC, exp_pc);
                chk("instr", bus.Instr, exp_pc ^ K);
                chk("pc_plus_4", bus.PC_Plus_4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (bus.PCSrc) begin
                if (redir_q.size() > 0) exp_pc = redir_q.pop_front() & 32'hFFFF_FFFC;
                else fail("redir_q_empty");
            end
            p_hold = bus.IMemReq && !bus.IMemValid;
            p_addr = bus.IMemAddr;
        end
    end

    task automatic tick();
        @(posedge CLK); #2;
    endtask

    task automatic redirect(input logic [31:0] t);
        bus.PCSrc  = 1'b1;
        bus.Result = t;
        redir_q.push_back(t);
    endtask

    task automatic wait_completion(input string nm);
        int n = 0;
        while (!(bus.IMemReq && bus.IMemValid) && n < 50) begin tick(); n++; end
        if (n >= 50) fail(nm);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!bus.InstrValid && n < 50) begin tick(); n++; end
        if (n >= 50) fail(nm);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!bus.IMemReq && n < 50) begin tick(); n++; end
        if (n >= 50) fail(nm);
    endtask

    logic [31:0] p, ins, old;
    int          xfers;
    bit          frozen;

    initial begin
        bus.PCSrc  = 1'b0;
        bus.Result = 32'h0;
        bus.Stall  = 1'b0;
        repeat (3) tick();
        chk("rst_req", {31'b0, bus.IMemReq}, 32'd0);
        chk("rst_valid", {31'b0, bus.InstrValid}, 32'd0);
        chk("rst_pc", bus.PC, RV);
        chk("rst_pc4", bus.PC_Plus_4, RV + 32'd4);
        chk("rst_addr", bus.IMemAddr, RV);
        chk("rst_instr", bus.Instr, 32'h0);

        // sequential stream, zero-wait memory
        Reset = 1'b1;
        fixed_wait = 0;
        wait_req("stream_start");
        for (int i = 0; i < 6; i++) begin
            chk("stream_addr", bus.IMemAddr, RV + 32'(4 * i));
            if (i >= 2) chk("stream_pc", bus.PC, bus.IMemAddr - 32'd4);
            tick();
        end

        // stall four cycles: Instr frozen, exactly one word into the skid, then HOLD
        wait_valid("stall_valid");
        bus.Stall = 1'b1;
        p = bus.PC;
        ins = bus.Instr;
        xfers = 0;
        frozen = 1;
        for (int i = 0; i < 4; i++) begin
            if (bus.IMemReq && bus.IMemValid) xfers++;
            tick();
            if (bus.PC !== p || bus.Instr !== ins || !bus.InstrValid) frozen = 0;
        end
        chk("stall_frozen", {31'b0, frozen}, 32'd1);
        chk("stall_xfers", 32'(xfers), 32'd1);
        chk("hold_no_req", {31'b0, bus.IMemReq}, 32'd0);
        bus.Stall = 1'b0;
        tick();
        chk("skid_pc", bus.PC, p + 32'd4);
        chk("skid_valid", {31'b0, bus.InstrValid}, 32'd1);

        // redirect in the first wait cycle of a 3-wait access
        fixed_wait = 3;
        wait_completion("kill_pre");
        tick();
        old = bus.IMemAddr;
        redirect(32'h0000_0103);
        tick();
        bus.PCSrc = 1'b0;
        chk("kill_addr", bus.IMemAddr, old);
        chk("kill_req", {31'b0, bus.IMemReq}, 32'd1);
        wait_completion("kill_done");
        tick();
        chk("redir_addr", bus.IMemAddr, 32'h0000_0100);
        wait_valid("redir_valid");
        chk("redir_pc", bus.PC, 32'h0000_0100);

        // back-to-back redirects, last one on the completion cycle
        wait_completion("bb_pre");
        tick();
        redirect(32'h0000_0180);
        tick();
        redirect(32'h0000_0200);
        tick();
        bus.PCSrc = 1'b0;
        wait_completion("bb_done");
        redirect(32'h0000_0300);
        tick();
        bus.PCSrc = 1'b0;
        chk("bb_addr", bus.IMemAddr, 32'h0000_0300);
        wait_valid("bb_valid");
        chk("bb_pc", bus.PC, 32'h0000_0300);

        // wrap-around at the top of the address space
        fixed_wait = 0;
        tick();
        redirect(32'hFFFF_FFF8);
        tick();
        bus.PCSrc = 1'b0;
        wait_valid("wrap_valid");
        chk("wrap_pc0", bus.PC, 32'hFFFF_FFF8);
        tick();
        chk("wrap_pc1", bus.PC, 32'hFFFF_FFFC);
        chk("wrap_pc4", bus.PC_Plus_4, 32'h0000_0000);
        tick();
        chk("wrap_pc2", bus.PC, 32'h0000_0000);

        // reset asserted between edges during a wait
        fixed_wait = 3;
        wait_completion("mr_pre");
        tick();
        #2;
        Reset = 1'b0;
        #1;
        chk("mr_req", {31'b0, bus.IMemReq}, 32'd0);
        chk("mr_valid", {31'b0, bus.InstrValid}, 32'd0);
        chk("mr_pc", bus.PC, RV);
        repeat (2) tick();
        Reset = 1'b1;
        wait_req("mr_req_again");
        chk("mr_addr", bus.IMemAddr, RV);
        wait_valid("mr_valid_again");
        chk("mr_pc_after", bus.PC, RV);

        // random traffic against the scoreboard
        fixed_wait = -1;
        for (int i = 0; i < 1500; i++) begin
            bus.Stall = ($urandom_range(99, 0) < 30);
            if ($urandom_range(99, 0) < 4) redirect($urandom);
            else bus.PCSrc = 1'b0;
            tick();
        end
        bus.PCSrc = 1'b0;
        bus.Stall = 1'b0;
        repeat (10) tick();
        chk("progress", {31'b0, n_consumed > 300}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
